riscv_wb_buffer: RTL
====================

Name: riscv_wb_buffer

Overview:
- Writeback buffer between the LSU load-response path and write port B of the integer/FP register file.
- Queues load results in a small in-order FIFO and drains one per cycle into port B (waddr_b/wdata_b/we_b).
- Cancels buffered loads that a younger port-A (ALU) write supersedes.
- Exports a pending-destination mask so the ID stage can stall on RAW hazards.

Parameters:
- ADDR_WIDTH, 5, register address width; 6 when FPU=1 (MSB selects the FP file).
- DATA_WIDTH, 32, data width.
- DEPTH, 2, FIFO entries; power of two, ≥2.
- FPU, 0, 1 = FP register addresses are in use.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid_i  in  1  load result valid
- in_ready_o  out  1  buffer can accept
- in_addr_i  in  ADDR_WIDTH  destination register
- in_data_i  in  DATA_WIDTH  load data
- we_a_i  in  1  port-A write enable (observed for kill)
- waddr_a_i  in  ADDR_WIDTH  port-A write address
- wb_stall_i  in  1  port B unavailable this cycle
- flush_i  in  1  synchronous discard of all entries
- we_b_o  out  1  port-B write enable
- waddr_b_o  out  ADDR_WIDTH  port-B address
- wdata_b_o  out  DATA_WIDTH  port-B data
- pending_o  out  2**ADDR_WIDTH  one bit per register with a live buffered write
- empty_o  out  1  no entries held

Behaviour:
- Storage: DEPTH entries {live, addr, data}; read pointer, write pointer, occupancy counter (clog2(DEPTH)+1 bits); pointers wrap modulo DEPTH.
- Reset: entries cleared and pointers zero.
  - Outputs at reset: we_b_o=0, waddr_b_o=0, wdata_b_o=0, pending_o=0, empty_o=1, in_ready_o=1.
- Accept: in_valid_i && in_ready_o.
  - Push: the entry is written at the write pointer with live=1, unless in_addr_i==0.
  - Address 0 (x0): handshake completes, nothing is stored.
- Pop condition: head is live and !wb_stall_i, OR head is dead (dead heads pop regardless of stall).
- in_ready_o = (count<DEPTH) || pop this cycle. This is combinational from wb_stall_i.
- Output is driven from the head entry.
  - we_b_o = !empty && head.live && !wb_stall_i.
  - waddr_b_o and wdata_b_o = head fields. They hold their last value when empty.
- Latency: a push in cycle N appears on port B at the earliest in cycle N+1.
- Kill: when we_a_i=1, every stored entry with addr==waddr_a_i gets live cleared.
  - An entry accepted in the same cycle with in_addr_i==waddr_a_i is stored dead.
  - The port-A write is younger and must not be overwritten.
- pending_o: OR over live entries of onehot(addr). It updates the cycle after a push, kill or pop.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - Push while full is legal only when the head pops the same cycle.
- flush_i: next cycle count=0 and all entries are dead. A push in the flush cycle is discarded. we_b_o is still driven normally in the flush cycle.
- Reset mid-drain: all state clears immediately. No partial write.
- Ordering: strict FIFO. Entries never overtake one another.

Optional Feature:
- Macro: RISCV_WB_BYPASS_EN.
- Defined: when the buffer is empty, wb_stall_i=0, in_valid_i=1, in_addr_i!=0 and there is no kill match, the write goes combinationally to port B in the same cycle.
  - In that case the entry is not stored and pending_o is unaffected.
  - Latency is 0.
- Undefined: every write passes through the FIFO, minimum latency 1.

Test Plan:
- Reset: assert rst_n=0 mid-drain → we_b_o=0, empty_o=1, pending_o=0, in_ready_o=1 immediately.
- Single load: push x5=0xDEADBEEF, no stall → next cycle we_b_o=1, waddr_b_o=5, wdata_b_o=0xDEADBEEF; pending_o bit5=1 for exactly that cycle.
- Fill/back-pressure: wb_stall_i=1, push x3=0x11 and x4=0x22 → in_ready_o=0. Release the stall → port B writes x3 then x4 on consecutive cycles, and in_ready_o=1 during the first pop.
- Kill: stall, buffer x7=0xAA, then we_a_i=1 with waddr_a_i=7 → pending_o bit7=0. Release the stall → no we_b_o to x7, the slot pops in 1 cycle, empty_o=1.
- x0 and flush:
  - Push addr 0 → never any we_b_o, pending_o=0.
  - Buffer x9 and x10, then assert flush_i → empty_o=1 next cycle, no writes.
- Bypass (macro defined): empty buffer, push x12=0x5 → we_b_o=1 in the same cycle, empty_o stays 1. With the macro undefined → the write occurs next cycle.

Source files
------------

// File: rtl/riscv_wb_buffer_if.sv
// riscv_wb_buffer_if: load-response input, port-A kill snoop and port-B writeback bundle.
interface riscv_wb_buffer_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                       in_valid_i;
    logic                       in_ready_o;
    logic [ADDR_WIDTH-1:0]      in_addr_i;
    logic [DATA_WIDTH-1:0]      in_data_i;
    logic                       we_a_i;
    logic [ADDR_WIDTH-1:0]      waddr_a_i;
    logic                       wb_stall_i;
    logic                       flush_i;
    logic                       we_b_o;
    logic [ADDR_WIDTH-1:0]      waddr_b_o;
    logic [DATA_WIDTH-1:0]      wdata_b_o;
    logic [2**ADDR_WIDTH-1:0]   pending_o;
    logic                       empty_o;

    modport slave (
        input  in_valid_i, in_addr_i, in_data_i, we_a_i, waddr_a_i, wb_stall_i, flush_i,
        output in_ready_o, we_b_o, waddr_b_o, wdata_b_o, pending_o, empty_o
    );

    modport master (
        output in_valid_i, in_addr_i, in_data_i, we_a_i, waddr_a_i, wb_stall_i, flush_i,
        input  in_ready_o, we_b_o, waddr_b_o, wdata_b_o, pending_o, empty_o
    );
endinterface

// File: rtl/riscv_wb_buffer.sv
// riscv_wb_buffer: in-order load writeback FIFO feeding register-file port B, with port-A kill.
// Optional RISCV_WB_BYPASS_EN sends a load straight to port B when the buffer is empty.
module riscv_wb_buffer #(
    parameter int FPU        = 0,
    parameter int ADDR_WIDTH = (FPU != 0) ? 6 : 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input logic              clk,
    input logic              rst_n,
    riscv_wb_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int NR = 2**ADDR_WIDTH;

    logic                  r_live [DEPTH];
    logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [PW-1:0]         r_rd;
    logic [PW-1:0]         r_wr;
    logic [CW-1:0]         r_cnt;
    logic [ADDR_WIDTH-1:0] r_last_addr;
    logic [DATA_WIDTH-1:0] r_last_data;

    logic                  w_empty;
    logic                  w_head_live;
    logic                  w_pop;
    logic                  w_ready;
    logic                  w_acc;
    logic                  w_in_kill;
    logic                  w_byp;
    logic                  w_push;
    logic [NR-1:0]         w_pending;

    assign w_empty     = (r_cnt == '0);
    assign w_head_live = r_live[r_rd];
    // Killed heads carry nothing to write, so they drain even under stall.
    assign w_pop       = !w_empty && (!w_head_live || !bus.wb_stall_i);
    assign w_ready     = (r_cnt < CW'(DEPTH)) || w_pop;
    assign w_acc       = bus.in_valid_i && w_ready;
    assign w_in_kill   = bus.we_a_i && (bus.waddr_a_i == bus.in_addr_i);

`ifdef RISCV_WB_BYPASS_EN
    assign w_byp = w_empty && !bus.wb_stall_i && bus.in_valid_i && (bus.in_addr_i != '0) &&
                   !w_in_kill && !bus.flush_i;
`else
    assign w_byp = 1'b0;
`endif

    assign w_push = w_acc && (bus.in_addr_i != '0) && !bus.flush_i && !w_byp;

    assign bus.in_ready_o = w_ready;
    assign bus.empty_o    = w_empty;
    assign bus.we_b_o     = (!w_empty && w_head_live && !bus.wb_stall_i) || w_byp;
    assign bus.waddr_b_o  = w_byp ? bus.in_addr_i : w_empty ? r_last_addr : r_addr[r_rd];
    assign bus.wdata_b_o  = w_byp ? bus.in_data_i : w_empty ? r_last_data : r_data[r_rd];
    assign bus.pending_o  = w_pending;

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < DEPTH; i++)
            w_pending = w_pending | (r_live[i] ? NR'(1) << r_addr[i] : NR'(0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_live[i] <= 1'b0;
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
            r_rd        <= '0;
            r_wr        <= '0;
            r_cnt       <= '0;
            r_last_addr <= '0;
            r_last_data <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (bus.we_a_i && r_addr[i] == bus.waddr_a_i) r_live[i] <= 1'b0;
            if (w_pop) begin
                r_live[r_rd] <= 1'b0;
                r_rd         <= r_rd + PW'(1);
            end
            // A push into the slot being popped (full buffer) must win over the clear above.
            if (w_push) begin
                r_live[r_wr] <= !w_in_kill;
                r_addr[r_wr] <= bus.in_addr_i;
                r_data[r_wr] <= bus.in_data_i;
                r_wr         <= r_wr + PW'(1);
            end
            if (w_pop || w_byp) begin
                r_last_addr <= bus.waddr_b_o;
                r_last_data <= bus.wdata_b_o;
            end
            if (bus.flush_i) begin
                for (int i = 0; i < DEPTH; i++) r_live[i] <= 1'b0;
                r_rd  <= '0;
                r_wr  <= '0;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            end
        end
    end
endmodule
